// File: rtl/rfds_pkg.sv
// Shared definitions for the runtime delay-setting controller: default widths,
// the slew FSM encoding and the downstream delay-line latency used by benches.
package rfds_pkg;

  localparam int unsigned DELAY_W        = 15;
  localparam int unsigned RATE_W         = 16;
  localparam int unsigned DELAY_LINE_LAT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StSlewUp,
    StSlewDown,
    StJump
  } slew_state_e;

endpackage

// File: rtl/valid_divider.sv
// Counts enabled samples and emits a one-cycle tick on every rate-th one.
// The tick is combinational so the owner can act on the same edge.
module valid_divider
  import rfds_pkg::*;
#(
  parameter int unsigned RateW = RATE_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [RateW-1:0] rate_i,
  output logic             tick_o
);

  logic [RateW-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == rate_i - RateW'(1));
  assign tick_o = en_i & ~clear_i & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + RateW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/delay_slew.sv
// Moves the delay-line setting toward a commanded target one sample at a time,
// paced by the sample strobe, so delay changes never jump unless asked to.
module delay_slew
  import rfds_pkg::*;
#(
  parameter int unsigned DelayW = DELAY_W,
  parameter int unsigned RateW  = RATE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_valid_i,
  input  logic              freeze_i,
  input  logic              cfg_stb_i,
  input  logic [DelayW-1:0] cfg_target_i,
  input  logic [RateW-1:0]  cfg_rate_i,
  output logic              cfg_ack_o,
  output logic [DelayW-1:0] delay_o,
  output logic              busy_o,
  output logic              step_o
);

  slew_state_e       state_q, state_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic [DelayW-1:0] target_q, target_d;
  logic [RateW-1:0]  rate_q, rate_d;
  logic              ack_q, ack_d;
  logic              step_q, step_d;
  logic              adv, slewing, tick;

  assign adv     = data_valid_i & ~freeze_i;
  assign slewing = (state_q == StSlewUp) || (state_q == StSlewDown);

  valid_divider #(
    .RateW(RateW)
  ) u_divider (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(cfg_stb_i),
    .en_i   (adv & slewing),
    .rate_i (rate_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    target_d = target_q;
    rate_d   = rate_q;
    ack_d    = 1'b0;
    step_d   = 1'b0;
    // A command pre-empts any pacing on the same edge.
    if (cfg_stb_i) begin
      target_d = cfg_target_i;
      rate_d   = cfg_rate_i;
      ack_d    = 1'b1;
      if (cfg_target_i == delay_q) begin
        state_d = StIdle;
      end else if (cfg_rate_i == '0) begin
        state_d = StJump;
      end else if (cfg_target_i > delay_q) begin
        state_d = StSlewUp;
      end else begin
        state_d = StSlewDown;
      end
    end else begin
      unique case (state_q)
        StSlewUp: begin
          if (tick) begin
            delay_d = delay_q + DelayW'(1);
            step_d  = 1'b1;
            if (delay_d == target_q) state_d = StIdle;
          end
        end
        StSlewDown: begin
          if (tick) begin
            delay_d = delay_q - DelayW'(1);
            step_d  = 1'b1;
            if (delay_d == target_q) state_d = StIdle;
          end
        end
        StJump: begin
          if (adv) begin
            delay_d = target_q;
            step_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      delay_q  <= '0;
      target_q <= '0;
      rate_q   <= '0;
      ack_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      ack_q    <= ack_d;
      step_q   <= step_d;
    end
  end

  assign cfg_ack_o = ack_q;
  assign delay_o   = delay_q;
  assign step_o    = step_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_delay_slew.sv
// Scenario bench for delay_slew: expected delay values are queued when a command
// is issued and compared against the DUT on every step pulse.
module tb_delay_slew;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic        frz = 1'b0;
  logic        stb = 1'b0;
  logic [14:0] tgt = '0;
  logic [15:0] rate = '0;
  logic        ack;
  logic [14:0] delay;
  logic        busy;
  logic        step;

  int n_checks = 0;
  int n_pass = 0;
  int n_steps = 0;
  int cyc = 0;
  logic [14:0] exp_q[$];
  int step_cyc[$];

  delay_slew dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .data_valid_i(dv),
    .freeze_i    (frz),
    .cfg_stb_i   (stb),
    .cfg_target_i(tgt),
    .cfg_rate_i  (rate),
    .cfg_ack_o   (ack),
    .delay_o     (delay),
    .busy_o      (busy),
    .step_o      (step)
  );

  always #5 clk = ~clk;

  // Scoreboard: each step pulse must show the next queued delay value.
  always @(posedge clk) begin
    logic [14:0] e;
    #1;
    cyc++;
    if (step === 1'b1) begin
      n_steps++;
      step_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL step_unexpected: delay=%0d with no expected step queued", delay);
      end else begin
        e = exp_q.pop_front();
        if (delay !== e) $display("FAIL step_value: delay=%0d expected %0d", delay, e);
        else n_pass++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [14:0] t, input logic [15:0] r);
    stb  = 1'b1;
    tgt  = t;
    rate = r;
    cycle();
    stb  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (delay !== 15'd0) $display("FAIL reset_delay: got %0d want 0", delay); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
    n_checks++; if (step !== 1'b0) $display("FAIL reset_step: got %b want 0", step); else n_pass++;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_slew_up_rate1();
    int s0;
    dv = 1'b1;
    for (int v = 1; v <= 10; v++) exp_q.push_back(15'(v));
    s0 = n_steps;
    send(15'd10, 16'd1);
    n_checks++; if (ack !== 1'b1) $display("FAIL up_ack: got %b want 1", ack); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL up_busy_start: got %b want 1", busy); else n_pass++;
    n_checks++; if (delay !== 15'd0) $display("FAIL up_delay_start: got %0d want 0", delay); else n_pass++;
    cycle();
    n_checks++; if (ack !== 1'b0) $display("FAIL up_ack_pulse: got %b want 0", ack); else n_pass++;
    n_checks++; if (delay !== 15'd1) $display("FAIL up_first_step: got %0d want 1", delay); else n_pass++;
    for (int i = 0; i < 9; i++) cycle();
    n_checks++; if (delay !== 15'd10) $display("FAIL up_final: got %0d want 10", delay); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL up_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (n_steps - s0 !== 10) $display("FAIL up_step_count: got %0d want 10", n_steps - s0); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL up_queue: %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_slew_down_paced();
    dv = 1'b0;
    exp_q.push_back(15'd9);
    exp_q.push_back(15'd8);
    exp_q.push_back(15'd7);
    send(15'd7, 16'd4);
    n_checks++; if (ack !== 1'b1) $display("FAIL down_ack: got %b want 1", ack); else n_pass++;
    step_cyc.delete();
    for (int i = 0; i < 32; i++) begin
      dv = (i % 2 == 0);
      cycle();
    end
    dv = 1'b0;
    n_checks++; if (step_cyc.size() != 3) $display("FAIL down_step_count: got %0d want 3", step_cyc.size()); else n_pass++;
    if (step_cyc.size() == 3) begin
      n_checks++;
      if (step_cyc[1] - step_cyc[0] != 8 || step_cyc[2] - step_cyc[1] != 8)
        $display("FAIL down_spacing: got %0d,%0d want 8,8",
                 step_cyc[1] - step_cyc[0], step_cyc[2] - step_cyc[1]);
      else n_pass++;
    end
    n_checks++; if (delay !== 15'd7) $display("FAIL down_final: got %0d want 7", delay); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL down_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mid_slew_retarget();
    int s0;
    dv = 1'b1;
    exp_q.push_back(15'd6);
    exp_q.push_back(15'd5);
    send(15'd5, 16'd1);
    cycle();
    cycle();
    n_checks++; if (delay !== 15'd5) $display("FAIL mid_setup: got %0d want 5", delay); else n_pass++;
    send(15'd20, 16'd3);
    cycle();
    cycle();
    n_checks++; if (delay !== 15'd5) $display("FAIL mid_pre: got %0d want 5", delay); else n_pass++;
    exp_q.push_back(15'd4);
    exp_q.push_back(15'd3);
    s0 = n_steps;
    send(15'd3, 16'd3);
    n_checks++; if (step !== 1'b0) $display("FAIL mid_cmd_step: got %b want 0", step); else n_pass++;
    n_checks++; if (delay !== 15'd5) $display("FAIL mid_no_snap: got %0d want 5", delay); else n_pass++;
    cycle();
    cycle();
    n_checks++; if (delay !== 15'd5) $display("FAIL mid_cnt_restart: got %0d want 5", delay); else n_pass++;
    cycle();
    n_checks++; if (delay !== 15'd4) $display("FAIL mid_first_down: got %0d want 4", delay); else n_pass++;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++; if (delay !== 15'd3 || busy !== 1'b0)
      $display("FAIL mid_final: delay=%0d busy=%b want 3/0", delay, busy); else n_pass++;
    n_checks++; if (n_steps - s0 !== 2) $display("FAIL mid_steps: got %0d want 2", n_steps - s0); else n_pass++;
  endtask

  task automatic test_jump_freeze();
    int s0;
    dv = 1'b1;
    exp_q.push_back(15'd0);
    send(15'd0, 16'd0);
    n_checks++; if (busy !== 1'b1 || delay !== 15'd3)
      $display("FAIL jump0_pending: delay=%0d busy=%b want 3/1", delay, busy); else n_pass++;
    cycle();
    n_checks++; if (delay !== 15'd0 || busy !== 1'b0)
      $display("FAIL jump0_done: delay=%0d busy=%b want 0/0", delay, busy); else n_pass++;
    frz = 1'b1;
    exp_q.push_back(15'd32767);
    s0 = n_steps;
    send(15'd32767, 16'd0);
    for (int i = 0; i < 5; i++) cycle();
    n_checks++; if (delay !== 15'd0 || busy !== 1'b1)
      $display("FAIL jump_frozen: delay=%0d busy=%b want 0/1", delay, busy); else n_pass++;
    frz = 1'b0;
    cycle();
    n_checks++; if (delay !== 15'd32767 || busy !== 1'b0)
      $display("FAIL jump_done: delay=%0d busy=%b want 32767/0", delay, busy); else n_pass++;
    cycle();
    n_checks++; if (n_steps - s0 !== 1) $display("FAIL jump_steps: got %0d want 1", n_steps - s0); else n_pass++;
  endtask

  task automatic test_top_down_and_reset();
    dv = 1'b0;
    exp_q.push_back(15'd32766);
    send(15'd0, 16'd1);
    dv = 1'b1;
    cycle();
    n_checks++; if (delay !== 15'd32766 || busy !== 1'b1)
      $display("FAIL top_down: delay=%0d busy=%b want 32766/1", delay, busy); else n_pass++;
    exp_q.push_back(15'd32765);
    cycle();
    send(15'd100, 16'd1);
    n_checks++; if (step !== 1'b0 || delay !== 15'd32765)
      $display("FAIL cmd_wins: step=%b delay=%0d want 0/32765", step, delay); else n_pass++;
    exp_q.push_back(15'd32764);
    cycle();
    n_checks++; if (delay !== 15'd32764) $display("FAIL after_cmd: got %0d want 32764", delay); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL queue_drain: %0d left want 0", exp_q.size()); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (delay !== 15'd0 || busy !== 1'b0 || step !== 1'b0 || ack !== 1'b0)
      $display("FAIL async_reset: delay=%0d busy=%b step=%b ack=%b want 0/0/0/0",
               delay, busy, step, ack);
    else n_pass++;
    cycle();
    n_checks++; if (delay !== 15'd0 || busy !== 1'b0)
      $display("FAIL reset_hold: delay=%0d busy=%b want 0/0", delay, busy); else n_pass++;
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_slew_up_rate1();
    test_slew_down_paced();
    test_mid_slew_retarget();
    test_jump_freeze();
    test_top_down_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
